// File: rtl/cnn2d_pixel_loader_if.sv
// Pixel stream and result handshakes between the image source/consumer and the CNN front-end loader.
interface cnn2d_pixel_loader_if #(
  parameter int unsigned PIX_W = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_class;

  // Loader side: consumes pixels, produces results.
  modport slave (
    input  s_valid, s_data, s_last, res_ready,
    output s_ready, res_valid, res_class
  );

  // Source/consumer side.
  modport master (
    output s_valid, s_data, s_last, res_ready,
    input  s_ready, res_valid, res_class
  );
endinterface

// File: rtl/cnn2d_pixel_loader.sv
// Streams a 28x28 8-bit image into a Q16.16 frame buffer for the CNN, waits a fixed settle time,
// then captures the CNN's class prediction and hands it out on a valid/ready result port.
module cnn2d_pixel_loader #(
  parameter int unsigned N_PIX         = 784,
  parameter int unsigned PIX_W         = 8,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned SCALE         = 514
) (
  input  logic                clk,
  input  logic                rstn,
  cnn2d_pixel_loader_if.slave s_if,
  output logic signed [31:0]  pixel_out [0:N_PIX-1],
  input  logic [3:0]          pred_in,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned IdxW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    StLoad,
    StHold,
    StResult
  } state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_res_valid, w_res_valid_d;
  logic [3:0]        r_res_class, w_res_class_d;
  logic              r_frame_err, w_frame_err_d;
  logic              w_wr_en;
  logic [31:0]       w_conv;

  // Maps 0..255 onto [-1.0, ~+1.0] in Q16.16; wraps modulo 2^32 by construction.
  assign w_conv = 32'(s_if.s_data) * 32'(SCALE) - 32'd65536;

  assign s_if.s_ready   = (r_state == StLoad);
  assign s_if.res_valid = r_res_valid;
  assign s_if.res_class = r_res_class;
  assign frame_err      = r_frame_err;
  assign busy           = (r_state == StHold) || (r_state == StResult);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StLoad;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_res_valid <= 1'b0;
      r_res_class <= 4'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_cnt       <= w_cnt_d;
      r_res_valid <= w_res_valid_d;
      r_res_class <= w_res_class_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_idx_d       = r_idx;
    w_cnt_d       = r_cnt;
    w_res_valid_d = r_res_valid;
    w_res_class_d = r_res_class;
    w_frame_err_d = 1'b0;
    w_wr_en       = 1'b0;
    unique case (r_state)
      StLoad: begin
        if (s_if.s_valid) begin
          w_wr_en = 1'b1;
          if (r_idx == IdxW'(N_PIX - 1)) begin
            // A full frame proceeds even if s_last is missing; the error is only flagged.
            w_idx_d       = '0;
            w_cnt_d       = '0;
            w_state_d     = StHold;
            w_frame_err_d = !s_if.s_last;
          end else if (s_if.s_last) begin
            w_idx_d       = '0;
            w_frame_err_d = 1'b1;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      StHold: begin
        if (r_cnt == CntW'(SETTLE_CYCLES - 1)) begin
          w_res_class_d = pred_in;
          w_res_valid_d = 1'b1;
          w_state_d     = StResult;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StResult: begin
        if (s_if.res_ready) begin
          w_res_valid_d = 1'b0;
          w_state_d     = StLoad;
        end
      end
      default: w_state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(N_PIX); i++) begin
        pixel_out[i] <= '0;
      end
    end else if (w_wr_en) begin
      pixel_out[r_idx] <= signed'(w_conv);
    end
  end

endmodule

// File: tb/tb_cnn2d_pixel_loader.sv
// Directed self-checking bench for cnn2d_pixel_loader: conversion, framing errors, settle timing,
// result back-pressure and asynchronous reset.
module tb_cnn2d_pixel_loader;

  localparam int NPix = 784;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [31:0] pixel_out [0:NPix-1];
  logic [3:0] pred_in = 4'd0;
  logic frame_err;
  logic busy;

  cnn2d_pixel_loader_if #(.PIX_W(8)) u_if ();

  cnn2d_pixel_loader u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_if      (u_if.slave),
    .pixel_out (pixel_out),
    .pred_in   (pred_in),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int fe_cycles = 0;
  logic [7:0] frame_buf [0:NPix-1];

  always @(negedge clk) if (frame_err === 1'b1) fe_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams beats first..last-1 of frame_buf; s_last on the final beat when with_last is set.
  task automatic send_beats(input int first, input int last, input bit with_last);
    for (int i = first; i < last; i++) begin
      u_if.s_valid = 1'b1;
      u_if.s_data  = frame_buf[i];
      u_if.s_last  = with_last && (i == last - 1);
      step();
    end
    u_if.s_valid = 1'b0;
    u_if.s_last  = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < NPix; i++) frame_buf[i] = v;
  endtask

  task automatic wait_result(input string tag, input logic [3:0] exp_class);
    int n;
    n = 0;
    while (u_if.res_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(u_if.res_valid), 32'd1);
    check({tag, "_class"}, 32'(u_if.res_class), 32'(exp_class));
    u_if.res_ready = 1'b1;
    step();
    u_if.res_ready = 1'b0;
    check({tag, "_done"}, 32'(u_if.res_valid), 32'd0);
  endtask

  initial begin
    int bad;
    int fe0;
    u_if.s_valid   = 1'b0;
    u_if.s_data    = 8'd0;
    u_if.s_last    = 1'b0;
    u_if.res_ready = 1'b0;
    #12;
    check("rst_s_ready", 32'(u_if.s_ready), 32'd1);
    check("rst_res_valid", 32'(u_if.res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pix0", pixel_out[0], 32'h0);
    rstn = 1'b1;
    step();

    // Test 1: all-zero frame; pred_in changes late so the sample instant is observable.
    fe0 = fe_cycles;
    fill(8'd0);
    pred_in = 4'd3;
    send_beats(0, NPix, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_s_ready", 32'(u_if.s_ready), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k == 7) pred_in = 4'd7;
      step();
      if (k < 8) check("t1_early_valid", 32'(u_if.res_valid), 32'd0);
    end
    check("t1_valid_at_8", 32'(u_if.res_valid), 32'd1);
    check("t1_class", 32'(u_if.res_class), 32'd7);
    bad = 0;
    for (int i = 0; i < NPix; i++) if (pixel_out[i] !== 32'hFFFF0000) bad++;
    check("t1_all_minus1", 32'(bad), 32'd0);
    check("t1_no_frame_err", 32'(fe_cycles - fe0), 32'd0);
    u_if.res_ready = 1'b1;
    step();
    u_if.res_ready = 1'b0;
    check("t1_valid_drop", 32'(u_if.res_valid), 32'd0);
    check("t1_s_ready_back", 32'(u_if.s_ready), 32'd1);

    // Test 2 + 5: conversion corners, then 20 cycles of result back-pressure.
    fill(8'd50);
    frame_buf[0]   = 8'd0;
    frame_buf[1]   = 8'd128;
    frame_buf[783] = 8'd255;
    pred_in = 4'd9;
    send_beats(0, NPix, 1'b1);
    check("t2_pix0", pixel_out[0], 32'hFFFF0000);
    check("t2_pix1", pixel_out[1], 32'h00000100);
    check("t2_pix783", pixel_out[783], 32'h0000FFFE);
    check("t2_pix400", pixel_out[400], 32'hFFFF6464);
    repeat (8) step();
    check("t5_valid", 32'(u_if.res_valid), 32'd1);
    pred_in = 4'd2;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (u_if.res_valid !== 1'b1 || u_if.res_class !== 4'd9 || u_if.s_ready !== 1'b0 ||
          busy !== 1'b1 || pixel_out[1] !== 32'h00000100) bad++;
      step();
    end
    check("t5_stable", 32'(bad), 32'd0);
    u_if.res_ready = 1'b1;
    step();
    u_if.res_ready = 1'b0;
    check("t5_valid_drop", 32'(u_if.res_valid), 32'd0);
    check("t5_s_ready", 32'(u_if.s_ready), 32'd1);

    // Test 3: early s_last aborts; words beyond the abort point are kept.
    fe0 = fe_cycles;
    fill(8'd128);
    send_beats(0, 100, 1'b1);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_s_ready", 32'(u_if.s_ready), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_pix150_kept", pixel_out[150], 32'hFFFF6464);
    step();
    check("t3_err_pulse", 32'(fe_cycles - fe0), 32'd1);
    fill(8'd200);
    frame_buf[783] = 8'd255;
    pred_in = 4'd4;
    send_beats(0, NPix, 1'b1);
    check("t3_busy_after", 32'(busy), 32'd1);
    check("t3_pix0", pixel_out[0], 32'h00009190);
    check("t3_pix783", pixel_out[783], 32'h0000FFFE);
    wait_result("t3", 4'd4);

    // Test 4: missing s_last on the final beat.
    fe0 = fe_cycles;
    fill(8'd255);
    pred_in = 4'd5;
    send_beats(0, NPix, 1'b0);
    check("t4_frame_err", 32'(frame_err), 32'd1);
    check("t4_busy", 32'(busy), 32'd1);
    wait_result("t4", 4'd5);
    check("t4_err_pulse", 32'(fe_cycles - fe0), 32'd1);

    // Test 6: reset mid-frame and mid-HOLD.
    fill(8'd128);
    send_beats(0, 400, 1'b0);
    rstn = 1'b0;
    #1;
    check("t6a_pix0", pixel_out[0], 32'h0);
    check("t6a_s_ready", 32'(u_if.s_ready), 32'd1);
    check("t6a_busy", 32'(busy), 32'd0);
    step();
    rstn = 1'b1;
    step();
    pred_in = 4'd6;
    send_beats(0, NPix, 1'b1);
    repeat (3) step();
    rstn = 1'b0;
    #1;
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_pix5", pixel_out[5], 32'h0);
    step();
    rstn = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (u_if.res_valid !== 1'b0) bad++;
    end
    check("t6b_no_result", 32'(bad), 32'd0);
    fill(8'd0);
    pred_in = 4'd8;
    send_beats(0, NPix, 1'b1);
    check("t6c_pix783", pixel_out[783], 32'hFFFF0000);
    wait_result("t6c", 4'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
